// File: rtl/addsub_chk_pkg.sv
// Shared types and golden model for the adder/subtractor response checker.
// Pure declarations: no state, no latency, no flow control.
package addsub_chk_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {cout, so}; y=0 is a 3-input add, y=1 is i2 - i1 - i0 with borrow out.
  function automatic logic [1:0] addsub_golden(input logic [2:0] i, input logic y);
    logic so;
    logic cout;
    so = i[2] ^ i[1] ^ i[0];
    if (!y) begin
      cout = (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
    end else begin
      cout = (~i[2] & i[1]) | (~i[2] & i[0]) | (i[1] & i[0]);
    end
    return {cout, so};
  endfunction

endpackage

// File: rtl/addsub_golden_unit.sv
// Combinational wrapper around the golden add/subtract function.
// Zero latency; no flow control, output follows inputs.
module addsub_golden_unit
  import addsub_chk_pkg::*;
(
  input  logic [2:0] i_vec,
  input  logic       i_y,
  output logic       o_so,
  output logic       o_cout
);

  logic [1:0] w_res;

  assign w_res  = addsub_golden(i_vec, i_y);
  assign o_so   = w_res[0];
  assign o_cout = w_res[1];

endmodule

// File: rtl/addsub_resp_checker.sv
// Checks adder/subtractor samples against the golden model; transfer updates state at the same edge, ready only in RUN.
// ADDSUB_CHK_FAIL_CAPTURE_EN builds first-failure capture; otherwise fail_valid/fail_vec are tied low.
module addsub_resp_checker
  import addsub_chk_pkg::*;
#(
  parameter int MAX_SAMPLES = 32,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               smp_valid,
  output logic               smp_ready,
  input  logic [2:0]         smp_i,
  input  logic               smp_y,
  input  logic               smp_so,
  input  logic               smp_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [NUM_VEC-1:0] seen,
  output logic               fail_valid,
  output logic [VEC_W-1:0]   fail_vec
);

  localparam int CNT_W = 8;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ERR_W-1:0]   r_err;
  logic [NUM_VEC-1:0] r_seen;
  logic               r_pass;

  logic               w_xfer;
  logic               w_start_run;
  logic [VEC_W-1:0]   w_vec;
  logic               w_gold_so;
  logic               w_gold_cout;
  logic               w_mismatch;
  logic [NUM_VEC-1:0] w_seen_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ERR_W-1:0]   w_err_nxt;
  logic               w_cov_full;
  logic               w_run_end;

  addsub_golden_unit u_golden (
    .i_vec  (smp_i),
    .i_y    (smp_y),
    .o_so   (w_gold_so),
    .o_cout (w_gold_cout)
  );

  assign w_xfer      = smp_valid && (r_state == RUN);
  assign w_start_run = start && (r_state != RUN);
  assign w_vec       = {smp_i, smp_y};
  assign w_mismatch  = {smp_cout, smp_so} != {w_gold_cout, w_gold_so};
  assign w_seen_nxt  = r_seen | ({{(NUM_VEC-1){1'b0}}, 1'b1} << w_vec);
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_err_nxt   = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
  assign w_cov_full  = &w_seen_nxt;
  // Coverage and budget may complete on the same transfer; either one ends the run once.
  assign w_run_end   = w_xfer && (w_cov_full || (w_cnt_nxt == CNT_W'(MAX_SAMPLES)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_run_end) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_err  <= '0;
      r_seen <= '0;
      r_pass <= 1'b0;
    end else if (w_start_run) begin
      r_cnt  <= '0;
      r_err  <= '0;
      r_seen <= '0;
      r_pass <= 1'b0;
    end else if (w_xfer) begin
      r_cnt  <= w_cnt_nxt;
      r_err  <= w_err_nxt;
      r_seen <= w_seen_nxt;
      if (w_run_end) begin
        r_pass <= w_cov_full && (w_err_nxt == '0);
      end
    end
  end

`ifdef ADDSUB_CHK_FAIL_CAPTURE_EN
  logic             r_fail_vld;
  logic [VEC_W-1:0] r_fail_vec;

  // Only the first mismatch of a run is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_vld <= 1'b0;
      r_fail_vec <= '0;
    end else if (w_start_run) begin
      r_fail_vld <= 1'b0;
      r_fail_vec <= '0;
    end else if (w_xfer && w_mismatch && !r_fail_vld) begin
      r_fail_vld <= 1'b1;
      r_fail_vec <= w_vec;
    end
  end

  assign fail_valid = r_fail_vld;
  assign fail_vec   = r_fail_vec;
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = '0;
`endif

  assign smp_ready = (r_state == RUN);
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign seen      = r_seen;

endmodule

// File: tb/tb_addsub_resp_checker.sv
// Scoreboard bench for addsub_resp_checker: a default instance plus an ERR_W=2 instance sharing stimulus.
module tb_addsub_resp_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        smp_valid;
  logic [2:0]  smp_i;
  logic        smp_y;
  logic        smp_so;
  logic        smp_cout;

  logic        smp_ready, busy, done, pass, fail_valid;
  logic [7:0]  err_cnt;
  logic [15:0] seen;
  logic [3:0]  fail_vec;

  logic        s_ready, s_busy, s_done, s_pass, s_fail_valid;
  logic [1:0]  s_err;
  logic [15:0] s_seen;
  logic [3:0]  s_fail_vec;

  addsub_resp_checker #(.MAX_SAMPLES(32), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_i(smp_i), .smp_y(smp_y), .smp_so(smp_so), .smp_cout(smp_cout),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .seen(seen),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  addsub_resp_checker #(.MAX_SAMPLES(32), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(s_ready),
    .smp_i(smp_i), .smp_y(smp_y), .smp_so(smp_so), .smp_cout(smp_cout),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err), .seen(s_seen),
    .fail_valid(s_fail_valid), .fail_vec(s_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  err;
    logic [1:0]  err2;
    logic [15:0] seen;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int          m_cnt;
  logic [7:0]  m_err;
  logic [1:0]  m_err2;
  logic [15:0] m_seen;
  bit          m_fail_vld;
  logic [3:0]  m_fail_vec;
  bit          m_done;

  // Reference computed arithmetically: y=0 adds, y=1 subtracts with borrow as the sign.
  function automatic logic [1:0] ref_out(input logic [3:0] v);
    int a, b, c, r;
    logic [1:0] o;
    a = int'(v[3]); b = int'(v[2]); c = int'(v[1]);
    if (!v[0]) begin
      r = a + b + c;
      o = r[1:0];
    end else begin
      r = a - b - c;
      o = {r < 0, r[0]};
    end
    return o;
  endfunction

  task automatic model_start();
    m_cnt = 0; m_err = '0; m_err2 = '0; m_seen = '0;
    m_fail_vld = 0; m_fail_vec = '0; m_done = 0;
    sb.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
    checks++;
    if (busy !== 1'b1 || smp_ready !== 1'b1 || done !== 1'b0 || pass !== 1'b0 ||
        err_cnt !== 8'd0 || seen !== 16'd0) begin
      errors++;
      $display("FAIL start_entry: busy=%b ready=%b done=%b pass=%b err=%0d seen=%h, required 1 1 0 0 0 0000",
               busy, smp_ready, done, pass, err_cnt, seen);
    end
  endtask

  task automatic send(input logic [3:0] v, input bit bad);
    logic [1:0] g;
    exp_t e;
    int n;
    g = ref_out(v);
    if (bad) g = ~g;
    smp_i = v[3:1]; smp_y = v[0]; smp_cout = g[1]; smp_so = g[0];
    smp_valid = 1'b1;
    m_cnt++;
    m_seen[v] = 1'b1;
    if (bad) begin
      if (m_err != 8'hFF) m_err++;
      if (m_err2 != 2'b11) m_err2++;
      if (!m_fail_vld) begin
        m_fail_vld = 1;
        m_fail_vec = v;
      end
    end
    m_done = (m_seen == 16'hFFFF) || (m_cnt == 32);
    e.err = m_err; e.err2 = m_err2; e.seen = m_seen; e.done = m_done;
    sb.push_back(e);
    n = 0;
    while (smp_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (smp_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", smp_ready, n);
      void'(sb.pop_front());
      return;
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (err_cnt !== e.err || s_err !== e.err2 || seen !== e.seen ||
        done !== e.done || busy !== !e.done) begin
      errors++;
      $display("FAIL xfer vec=%h n=%0d: err=%0d err2=%0d seen=%h done=%b busy=%b, required %0d %0d %h %b %b",
               v, m_cnt, err_cnt, s_err, seen, done, busy, e.err, e.err2, e.seen, e.done, !e.done);
    end
  endtask

  task automatic check_end(input string name);
    bit         exp_pass;
    bit         exp_fv;
    logic [3:0] exp_fvec;
    exp_pass = (m_seen == 16'hFFFF) && (m_err == 8'd0);
`ifdef ADDSUB_CHK_FAIL_CAPTURE_EN
    exp_fv = m_fail_vld; exp_fvec = m_fail_vec;
`else
    exp_fv = 0; exp_fvec = 4'd0;
`endif
    smp_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || smp_ready !== 1'b0 || pass !== exp_pass ||
        err_cnt !== m_err || seen !== m_seen || fail_valid !== exp_fv || fail_vec !== exp_fvec) begin
      errors++;
      $display("FAIL %s: done=%b busy=%b ready=%b pass=%b err=%0d seen=%h fv=%b fvec=%h, required 1 0 0 %b %0d %h %b %h",
               name, done, busy, smp_ready, pass, err_cnt, seen, fail_valid, fail_vec,
               exp_pass, m_err, m_seen, exp_fv, exp_fvec);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (smp_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0 ||
        seen !== 16'd0 || fail_valid !== 1'b0 || fail_vec !== 4'd0 || s_err !== 2'd0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b done=%b pass=%b err=%0d seen=%h fv=%b fvec=%h err2=%0d, required all 0",
               name, smp_ready, busy, done, pass, err_cnt, seen, fail_valid, fail_vec, s_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    smp_valid = 1'b1; smp_i = 3'b101; smp_y = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle_valid_ignored");
    smp_valid = 1'b0;
  endtask

  task automatic test_sweep();
    do_start();
    for (int v = 0; v < 16; v++) send(4'(v), 1'b0);
    check_end("sweep_pass");
  endtask

  task automatic test_error();
    // valid alongside start in DONE: the start wins and nothing is sampled
    smp_valid = 1'b1; smp_i = 3'b111; smp_y = 1'b1;
    do_start();
    for (int v = 0; v < 16; v++) send(4'(v), v == 7);
    check_end("sweep_one_error");
  endtask

  task automatic test_repeat();
    do_start();
    for (int k = 0; k < 32; k++) send(4'b0000, 1'b0);
    check_end("budget_repeat");
  endtask

  task automatic test_simultaneous();
    do_start();
    for (int k = 0; k < 17; k++) send(4'b0000, 1'b0);
    for (int v = 1; v < 16; v++) send(4'(v), 1'b0);
    check_end("cov_and_budget");
  endtask

  task automatic idle_gap(input int n);
    smp_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      start = 1'($urandom_range(0, 1));
      smp_i = 3'($urandom_range(0, 7));
      smp_y = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || seen !== m_seen || err_cnt !== m_err) begin
      errors++;
      $display("FAIL gap_ignored: busy=%b seen=%h err=%0d, required 1 %h %0d", busy, seen, err_cnt, m_seen, m_err);
    end
  endtask

  task automatic test_random_valid();
    do_start();
    for (int v = 0; v < 16; v++) begin
      if (v != 0) idle_gap($urandom_range(1, 3));
      send(4'(v), 1'b0);
    end
    check_end("random_valid_pass");
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int v = 0; v < 7; v++) send(4'(v), v == 2);
    smp_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle_after_reset");
    do_start();
    for (int v = 0; v < 16; v++) send(4'(15 - v), 1'b0);
    check_end("sweep_after_reset");
  endtask

  task automatic test_saturation();
    do_start();
    for (int v = 0; v < 5; v++) send(4'(v), 1'b1);
    smp_valid = 1'b0;
    checks++;
    if (s_err !== 2'd3 || err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL err_saturation: err2=%0d err8=%0d, required 3 5", s_err, err_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; smp_valid = 1'b0; smp_i = '0; smp_y = 1'b0; smp_so = 1'b0; smp_cout = 1'b0;
    rst_n = 1'b0;
    model_start();
    @(negedge clk);
    test_reset();
    test_sweep();
    test_error();
    test_repeat();
    test_simultaneous();
    test_random_valid();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
